// File: rtl/ir_err_pkg.sv
// ir_err_pkg: shared types, default sizes and width helpers for the IR error engine.
package ir_err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam int DEF_NUM_PAIRS = 4;
    localparam int DEF_IR_W      = 12;
    localparam int DEF_ERR_W     = 16;

    // Accumulator width: worst case sum of 2^k*(2^irW-1) over numPairs pairs,
    // plus one sign bit, so no intermediate result can wrap.
    function automatic int accWidth(input int irW, input int numPairs);
        return irW + numPairs + 1;
    endfunction

    // Sensor index width: counts 0..2*numPairs-1, kept at least 2 bits so the
    // pair field (index without its LSB) is never empty.
    function automatic int idxWidth(input int numPairs);
        return $clog2(2 * numPairs) + 1;
    endfunction

endpackage

// File: rtl/ir_err_sm.sv
// ir_err_sm: control FSM and sensor-index counter for the IR error engine.
// Walks IDLE -> ACCUM (one sensor per cycle) -> OUT -> IDLE.
import ir_err_pkg::*;

module ir_err_sm #(
    parameter int NUM_PAIRS = DEF_NUM_PAIRS,
    parameter int IDX_W     = idxWidth(NUM_PAIRS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_irVld,
    input  logic             i_errVld,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_accept,
    output logic             o_accStep,
    output logic             o_outStep,
    output logic             o_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_PAIRS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             w_busy;

    // Busy covers the whole computation plus the cycle the result is presented,
    // so a strobe coincident with err_vld is also rejected.
    assign w_busy    = (r_state != ST_IDLE) || i_errVld;
    assign o_busy    = w_busy;
    assign o_accept  = i_irVld && !w_busy;
    assign o_accStep = (r_state == ST_ACCUM);
    assign o_outStep = (r_state == ST_OUT);
    assign o_idx     = r_idx;

    // State and sensor index advance; index restarts at R0 on every accepted strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (o_accept) begin
                        r_state <= ST_ACCUM;
                        r_idx   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_OUT;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ir_err_engine.sv
// ir_err_engine: weighted left/right IR error, sum of 2^k*(R[k]-L[k]),
// accumulated one sensor per cycle, saturated and optionally 2-tap averaged.
import ir_err_pkg::*;

module ir_err_engine #(
    parameter int NUM_PAIRS = DEF_NUM_PAIRS,
    parameter int IR_W      = DEF_IR_W,
    parameter int ERR_W     = DEF_ERR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PAIRS*IR_W-1:0] ir_r,
    input  logic [NUM_PAIRS*IR_W-1:0] ir_l,
    input  logic                      ir_vld,
    input  logic                      filt_en,
    input  logic                      clr_ovr,
    output logic signed [ERR_W-1:0]   error,
    output logic                      err_vld,
    output logic                      busy,
    output logic                      overrun,
    output logic                      sat
);

    localparam int ACC_W  = accWidth(IR_W, NUM_PAIRS);
    localparam int IDX_W  = idxWidth(NUM_PAIRS);
    localparam int PAIR_W = IDX_W - 1;
    localparam int EXT_W  = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

    logic [NUM_PAIRS*IR_W-1:0] r_capR;
    logic [NUM_PAIRS*IR_W-1:0] r_capL;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ERR_W-1:0]   r_error;
    logic                      r_errVld;
    logic                      r_overrun;
    logic                      r_sat;

    logic [IDX_W-1:0]          w_idx;
    logic [PAIR_W-1:0]         w_pair;
    logic                      w_side;
    logic                      w_accept;
    logic                      w_accStep;
    logic                      w_outStep;
    logic                      w_busy;
    logic [IR_W-1:0]           w_sel;
    logic [ACC_W-1:0]          w_term;
    logic signed [EXT_W-1:0]   w_accExt;
    logic                      w_clipHi;
    logic                      w_clipLo;
    logic [ERR_W-1:0]          w_satVal;
    logic signed [ERR_W:0]     w_filtSum;
    logic [ERR_W-1:0]          w_next;

    ir_err_sm #(
        .NUM_PAIRS (NUM_PAIRS),
        .IDX_W     (IDX_W)
    ) u_sm (
        .clk       (clk),
        .rst       (rst),
        .i_irVld   (ir_vld),
        .i_errVld  (r_errVld),
        .o_idx     (w_idx),
        .o_accept  (w_accept),
        .o_accStep (w_accStep),
        .o_outStep (w_outStep),
        .o_busy    (w_busy)
    );

    // Even index = right reading of the pair, odd index = left reading.
    assign w_pair = w_idx[IDX_W-1:1];
    assign w_side = w_idx[0];

    // Pick the captured reading addressed by the current sensor index.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (w_pair == PAIR_W'(k)) begin
                w_sel = w_side ? r_capL[k*IR_W +: IR_W] : r_capR[k*IR_W +: IR_W];
            end
        end
    end

    assign w_term = {{(ACC_W-IR_W){1'b0}}, w_sel} << w_pair;

    // Saturation compares at a width wider than both accumulator and output.
    assign w_accExt = {{(EXT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_clipHi = (w_accExt > SAT_MAX);
    assign w_clipLo = (w_accExt < SAT_MIN);
    assign w_satVal = w_clipHi ? {1'b0, {(ERR_W-1){1'b1}}} :
                      w_clipLo ? {1'b1, {(ERR_W-1){1'b0}}} :
                                 w_accExt[ERR_W-1:0];

    // Averaging filter: one extra bit for the sum, arithmetic shift gives floor.
    assign w_filtSum = {r_error[ERR_W-1], r_error} + {w_satVal[ERR_W-1], w_satVal};
    assign w_next    = filt_en ? w_filtSum[ERR_W:1] : w_satVal;

    // Capture readings on accept, accumulate one term per cycle, publish in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capR   <= '0;
            r_capL   <= '0;
            r_acc    <= '0;
            r_error  <= '0;
            r_errVld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_capR <= ir_r;
                r_capL <= ir_l;
                r_acc  <= '0;
            end else if (w_accStep) begin
                r_acc <= w_side ? (r_acc - w_term) : (r_acc + w_term);
            end
            if (w_outStep) begin
                r_error <= w_next;
            end
            r_errVld <= w_outStep;
        end
    end

    // Sticky status flags; a set event in the same cycle as clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            if (ir_vld && w_busy) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
            if (w_outStep && (w_clipHi || w_clipLo)) begin
                r_sat <= 1'b1;
            end else if (clr_ovr) begin
                r_sat <= 1'b0;
            end
        end
    end

    assign error   = r_error;
    assign err_vld = r_errVld;
    assign busy    = w_busy;
    assign overrun = r_overrun;
    assign sat     = r_sat;

endmodule

// File: tb/tb_ir_err_engine.sv
// tb_ir_err_engine: directed vectors for ir_err_engine with a queue-based scoreboard.
module tb_ir_err_engine;

    localparam int NP  = 4;
    localparam int IRW = 12;
    localparam int ERW = 16;
    localparam int VW  = NP * IRW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [VW-1:0]         ir_r;
    logic [VW-1:0]         ir_l;
    logic                  ir_vld;
    logic                  filt_en;
    logic                  clr_ovr;
    logic signed [ERW-1:0] error;
    logic                  err_vld;
    logic                  busy;
    logic                  overrun;
    logic                  sat;

    typedef struct {
        logic signed [ERW-1:0] err;
        logic                  sat;
        int                    issue;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleCnt   = 0;

    ir_err_engine #(
        .NUM_PAIRS (NP),
        .IR_W      (IRW),
        .ERR_W     (ERW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ir_r    (ir_r),
        .ir_l    (ir_l),
        .ir_vld  (ir_vld),
        .filt_en (filt_en),
        .clr_ovr (clr_ovr),
        .error   (error),
        .err_vld (err_vld),
        .busy    (busy),
        .overrun (overrun),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure result latency.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [VW-1:0] slot(input int k, input logic [IRW-1:0] v);
        logic [VW-1:0] t;
        t = '0;
        t[k*IRW +: IRW] = v;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle strobe, optionally queue its expected result, then scramble
    // the inputs so a late re-sample would show up as a wrong answer.
    task automatic applyStimulus(input logic [VW-1:0] r, input logic [VW-1:0] l,
                                 input logic filt, input logic wantResult,
                                 input logic signed [ERW-1:0] expErr, input logic expSat);
        exp_t e;
        ir_r    = r;
        ir_l    = l;
        filt_en = filt;
        ir_vld  = 1'b1;
        if (wantResult) begin
            e.err   = expErr;
            e.sat   = expSat;
            e.issue = cycleCnt;
            expQ.push_back(e);
        end
        waitCycles(1);
        ir_vld = 1'b0;
        ir_r   = ~r;
        ir_l   = ~l;
    endtask

    task automatic runTxn(input logic [VW-1:0] r, input logic [VW-1:0] l, input logic filt,
                          input logic signed [ERW-1:0] expErr, input logic expSat);
        applyStimulus(r, l, filt, 1'b1, expErr, expSat);
        waitCycles(11);
    endtask

    task automatic pulseClr();
        clr_ovr = 1'b1;
        waitCycles(1);
        clr_ovr = 1'b0;
    endtask

    // Monitor: every err_vld pops one expectation and checks value, flag and latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && err_vld) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_err_vld: got err_vld=1 error=%0d, expected no result", error);
            end else begin
                e = expQ.pop_front();
                checkOutput("error", error, e.err);
                checkOutput("sat_at_result", sat, e.sat);
                checkOutput("latency", cycleCnt - e.issue, 10);
            end
        end
    end

    // Watchdog so a stuck run still terminates with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int guard;
        rst = 1'b1; ir_r = '0; ir_l = '0; ir_vld = 1'b0; filt_en = 1'b0; clr_ovr = 1'b0;
        waitCycles(3);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_err_vld", err_vld, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_sat", sat, 0);
        rst = 1'b0;
        waitCycles(2);

        runTxn(slot(0, 12'd100), slot(0, 12'd40), 1'b0, 16'sd60, 1'b0);
        checkOutput("error_held", error, 60);
        runTxn(slot(3, 12'h100), '0, 1'b0, 16'sd2048, 1'b0);
        runTxn('0, slot(2, 12'h200), 1'b0, -16'sd2048, 1'b0);
        runTxn({NP{12'hFFF}}, '0, 1'b0, 16'sh7FFF, 1'b1);
        checkOutput("sat_sticky", sat, 1);
        pulseClr();
        checkOutput("sat_cleared", sat, 0);
        runTxn('0, {NP{12'hFFF}}, 1'b0, 16'sh8000, 1'b1);
        pulseClr();

        runTxn(slot(3, 12'h100), '0, 1'b0, 16'sd2048, 1'b0);
        runTxn(slot(0, 12'd100), slot(0, 12'd40), 1'b1, 16'sd1054, 1'b0);
        runTxn('0, '0, 1'b0, 16'sd0, 1'b0);
        runTxn('0, slot(0, 12'd3), 1'b1, -16'sd2, 1'b0);

        applyStimulus(slot(0, 12'd5), '0, 1'b0, 1'b1, 16'sd5, 1'b0);
        checkOutput("busy_after_accept", busy, 1);
        waitCycles(2);
        clr_ovr = 1'b1;
        applyStimulus(slot(0, 12'd9), slot(1, 12'd7), 1'b0, 1'b0, 16'sd0, 1'b0);
        clr_ovr = 1'b0;
        checkOutput("overrun_set_wins", overrun, 1);
        waitCycles(8);
        checkOutput("busy_released", busy, 0);
        pulseClr();
        checkOutput("overrun_cleared", overrun, 0);

        applyStimulus(slot(1, 12'd10), '0, 1'b0, 1'b1, 16'sd20, 1'b0);
        waitCycles(9);
        checkOutput("err_vld_cycle", err_vld, 1);
        checkOutput("busy_in_err_vld_cycle", busy, 1);
        applyStimulus(slot(0, 12'd1), '0, 1'b0, 1'b0, 16'sd0, 1'b0);
        applyStimulus(slot(0, 12'd7), slot(0, 12'd2), 1'b0, 1'b1, 16'sd5, 1'b0);
        waitCycles(11);
        checkOutput("overrun_on_err_vld", overrun, 1);
        pulseClr();

        applyStimulus(slot(2, 12'd50), '0, 1'b0, 1'b0, 16'sd0, 1'b0);
        waitCycles(5);
        rst = 1'b1;
        #1;
        checkOutput("abort_error", error, 0);
        checkOutput("abort_err_vld", err_vld, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_sat", sat, 0);
        waitCycles(1);
        rst = 1'b0;
        waitCycles(15);
        runTxn(slot(2, 12'd50), slot(1, 12'd3), 1'b0, 16'sd194, 1'b0);

        guard = 0;
        while (expQ.size() > 0 && guard < 50) begin
            waitCycles(1);
            guard++;
        end
        checkOutput("pending_results", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ir_err_engine.md
IR_ERR_ENGINE -- requirements
Module: ir_err_engine

Interface
REQ-001 Parameter NUM_PAIRS, default 4, number of left/right IR sensor pairs, legal range 1..8.
REQ-002 Parameter IR_W, default 12, unsigned width of each IR reading.
REQ-003 Parameter ERR_W, default 16, signed width of error output.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ir_r  input  NUM_PAIRS*IR_W  right readings, packed; slice k = [k*IR_W +: IR_W], k=0 innermost.
REQ-007 ir_l  input  NUM_PAIRS*IR_W  left readings, same packing.
REQ-008 ir_vld  input  1  one-cycle strobe: ir_r/ir_l valid this cycle.
REQ-009 filt_en  input  1  1 = 2-tap averaging filter on output, 0 = raw error.
REQ-010 clr_ovr  input  1  clears the overrun and sat sticky flags.
REQ-011 error  output  ERR_W  signed weighted error, held between updates.
REQ-012 err_vld  output  1  one-cycle pulse: error updated this cycle.
REQ-013 busy  output  1  high while a computation is in progress.
REQ-014 overrun  output  1  sticky: ir_vld arrived while busy.
REQ-015 sat  output  1  sticky: a result was clipped to ERR_W range.

Function
REQ-016 Error SHALL equal sum over k of 2^k*(ir_r[k] - ir_l[k]), computed signed at internal width IR_W+NUM_PAIRS+1 with no intermediate overflow.
REQ-017 FSM states IDLE, ACCUM, OUT; IDLE->ACCUM on ir_vld, ACCUM->OUT after 2*NUM_PAIRS cycles, OUT->IDLE unconditionally.
REQ-018 On ir_vld in IDLE, all readings SHALL be captured into internal registers and the accumulator cleared; later input changes SHALL not affect the result.
REQ-019 ACCUM SHALL process one sensor per cycle in order R0, L0, R1, L1, ...: add shifted right reading, subtract shifted left reading.
REQ-020 In OUT the accumulator SHALL be saturated to [-2^(ERR_W-1), 2^(ERR_W-1)-1]; clipping sets sat.
REQ-021 If filt_en=0, error <= saturated value; if filt_en=1, error <= (error + saturated value) >>> 1 (signed, floor), computed at ERR_W+1 bits; filt_en sampled in OUT.
REQ-022 err_vld SHALL pulse exactly 2*NUM_PAIRS+2 cycles after the ir_vld cycle (10 for defaults), coincident with the new error value.
REQ-023 busy SHALL be high from the cycle after accepted ir_vld through the err_vld cycle, inclusive.
REQ-024 ir_vld while busy SHALL be ignored (no recapture, no restart) and SHALL set overrun.
REQ-025 ir_vld in the same cycle as err_vld SHALL be ignored and set overrun; ir_vld on the following cycle SHALL be accepted.
REQ-026 clr_ovr SHALL clear overrun and sat; a simultaneous set event SHALL win.

Reset
REQ-027 Reset SHALL force state IDLE, error=0, err_vld=0, busy=0, overrun=0, sat=0, accumulator and capture registers 0.
REQ-028 Reset asserted mid-computation SHALL abort it; no err_vld SHALL follow deassertion.

Structure
REQ-029 Package ir_err_pkg SHALL hold the state enum, default parameter values and the internal-width constant function.
REQ-030 Control FSM and sensor-index counter SHALL be sub-module ir_err_sm; datapath (capture, mux, shift, accumulate, saturate, filter) stays in ir_err_engine.

Verification
REQ-031 Defaults, R0=100, L0=40, others 0, filt_en=0 -> error=60, err_vld 10 cycles after ir_vld, sat=0.
REQ-032 R3=0x100, all else 0 -> error=2048; then L2=0x200, all else 0 -> error=-2048.
REQ-033 All R=0xFFF, all L=0 -> sum 61425 clips to 0x7FFF, sat=1; all L=0xFFF, R=0 -> 0x8000.
REQ-034 filt_en=1, prior error=2048, new raw 60 -> error=1054; prior 0, raw -3 -> error=-2.
REQ-035 Second ir_vld 3 cycles after the first with different data -> result matches first data, overrun=1; clr_ovr -> overrun=0.
REQ-036 rst pulsed 5 cycles into ACCUM -> all outputs 0, no err_vld; next ir_vld computes correctly.
